// File: rtl/btn_pkg.sv
//------------------------------------------------------------------------------
// btn_pkg: shared constants and types for the push-button conditioner.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package btn_pkg;

  localparam int N_BTN_DEFAULT           = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_U = 4;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_chan.sv
//------------------------------------------------------------------------------
// btn_debounce_chan: one button channel -- synchronizer, stability counter,
// debounced level and one-cycle press/release pulses.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  edge_e         edge_d;

  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    edge_d    = EDGE_NONE;
    press_d   = 1'b0;
    release_d = 1'b0;
    // A candidate level must hold for DEBOUNCE_CYCLES consecutive cycles;
    // any return to the current level drops the partial count.
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        edge_d  = s2_q ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d   = (edge_d == EDGE_RISE);
    release_d = (edge_d == EDGE_FALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
//------------------------------------------------------------------------------
// btn_conditioner: N debounced push-button channels with sticky press events,
// per-channel interrupt enables and a registered interrupt output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_evt,
  input  logic [N_BTN-1:0] i_evt_clr,
  input  logic [N_BTN-1:0] i_irq_en,
  output logic             o_irq
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be in 1..2^24");
  end

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] release_p;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (i_btn[g]),
      .level_o  (level[g]),
      .press_o  (press[g]),
      .release_o(release_p[g])
    );
  end

  logic [N_BTN-1:0] evt_q, evt_d;
  logic             irq_q, irq_d;

  always_comb begin
    // OR-ing the press in after the clear lets a same-cycle set win.
    evt_d = (evt_q & ~i_evt_clr) | press;
    irq_d = |(evt_q & i_irq_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      irq_q <= irq_d;
    end
  end

  assign o_level   = level;
  assign o_press   = press;
  assign o_release = release_p;
  assign o_evt     = evt_q;
  assign o_irq     = irq_q;

endmodule

`default_nettype wire
